traffic_spawn_scheduler: RTL and testbench
==========================================

# traffic_spawn_scheduler

Sequences enemy-vehicle spawning for the road scene. Every frame it counts down a level-dependent spawn gap. It then pulses `rise` into the random car/truck generator and samples the returned `create_car` decision. If the decision is positive, it allocates a free object slot, a lane and a car/truck type, and hands the spawn to the slot logic over a valid/ack handshake. It sits between the frame timing, the random generator and the object-slot bank.

## Interface
Parameters:
- `N_SLOTS`, 4: number of object slots; `slot_busy` width.
- `N_LANES`, 4: number of road lanes; `spawn_lane` covers 0..N_LANES-1.
- `BASE_GAP`, 60: spawn gap in frames at level 0.
- `GAP_STEP`, 6: frames removed from the gap per level.
- `MIN_GAP`, 12: floor for the gap.
- `TRUCK_EVERY`, 4: every TRUCK_EVERY-th issued spawn is a truck.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: synchronous, active-low reset.
- `startOfFrame`, in, 1: one-cycle frame tick.
- `game_active`, in, 1: spawning enabled while high.
- `level`, in, 3: difficulty level 0..7; also drives the random generator directly.
- `create_car`, in, 1: decision from the random generator.
- `slot_busy`, in, N_SLOTS: bit i high means slot i is occupied.
- `rise`, out, 1: request pulse to the random generator.
- `spawn_valid`, out, 1: spawn offer pending.
- `spawn_slot`, out, $clog2(N_SLOTS): target slot.
- `spawn_lane`, out, $clog2(N_LANES): lane.
- `spawn_is_truck`, out, 1: 1 = truck, 0 = car.
- `spawn_ack`, in, 1: slot logic accepts the offer.

Reset is synchronous and active-low: one clock, `clk`; reset `resetN`, sampled on the rising edge only.

## Operation
- **States:** IDLE, GAP, REQ, WAIT_RND, DECIDE, ISSUE.
- **Gap value:** gap = max(MIN_GAP, BASE_GAP − level·GAP_STEP), computed unsigned in 8 bits. Level 7 with defaults gives 18.
- **IDLE:**
  - Gap counter is 0.
  - When `game_active`=1, load the gap counter with gap and go to GAP.
- **GAP:**
  - Decrement the counter on each `startOfFrame` tick.
  - When the counter is 0 and at least one `slot_busy` bit is 0, go to REQ.
  - If all slots are busy, stay in GAP at 0 and do not request.
- **REQ:** assert `rise` for exactly one cycle, then go to WAIT_RND.
- **WAIT_RND:** hold one cycle while the generator latches its decision, then go to DECIDE.
- **DECIDE:**
  - Sample `create_car`.
  - If 0 (skip): reload the gap counter and go to GAP. Lane pointer and spawn counter are unchanged.
  - If 1:
    - Latch `spawn_slot` as the lowest-index free slot, re-evaluated this cycle.
    - Latch `spawn_lane` from the lane pointer.
    - Latch `spawn_is_truck` = (spawn counter == TRUCK_EVERY−1).
    - Go to ISSUE.
    - If no slot is free in this cycle, treat it as a skip.
- **ISSUE:**
  - `spawn_valid`=1 with slot, lane and type held stable.
  - On `spawn_ack`=1:
    - Lane pointer advances by 1 mod N_LANES.
    - Spawn counter advances mod TRUCK_EVERY.
    - Reload the gap counter and go to GAP.
  - A change in `slot_busy` during ISSUE does not alter the latched offer.
- **Game stop:** `game_active`=0 in any state returns to IDLE next cycle.
  - `spawn_valid` and `rise` drop.
  - Gap counter clears.
  - Lane pointer and spawn counter keep their values.
- **Level change:** a change in `level` takes effect only at the next gap reload.

## Timing
- **Reset values:** state IDLE; `rise`=0, `spawn_valid`=0, `spawn_slot`=0, `spawn_lane`=0, `spawn_is_truck`=0; lane pointer, spawn counter and gap counter all 0. Reset has priority over all inputs, including mid-handshake.
- **Outputs:** all registered.
- **Request timing:** `rise` is high in the cycle after entering REQ. `create_car` is sampled 2 cycles after `rise` rises, which matches the generator's 1-cycle edge-detect latency.
- **Offer timing:** `spawn_valid` rises 1 cycle after DECIDE. An ack in the first ISSUE cycle completes the handshake; `spawn_valid` is low the following cycle. No combinational ack→valid path.
- **Frame tick collisions:** a `startOfFrame` tick coinciding with the reload cycle is not counted. A tick while in REQ, WAIT_RND, DECIDE or ISSUE is ignored.
- **Back-to-back spawns:** minimum distance between two `rise` pulses is gap frames plus 3 cycles.

## Test plan
- **Gap length:** reset, `game_active`=1, `level`=0, all slots free, `create_car` forced 1, ack immediately → first `rise` after exactly 60 `startOfFrame` ticks; `spawn_valid` 3 cycles after `rise`; slot 0, lane 0, car.
- **Level scaling:** `level`=7 → gap 18 frames. Level 6 changed mid-gap → current gap still 18, next gap 24.
- **Lane and truck rotation:** 8 consecutive accepted spawns → lanes 0,1,2,3,0,1,2,3; truck only on spawns 4 and 8.
- **Slot allocation and skip:** `slot_busy`=4'b1011 → `spawn_slot`=2. `slot_busy`=4'b1111 → no `rise` until a slot frees. `create_car`=0 → no `spawn_valid`, lane pointer unchanged, new gap started.
- **Handshake hold:** withhold `spawn_ack` for 10 cycles while toggling `slot_busy` → `spawn_valid`, slot, lane and type stable throughout; single acceptance on ack.
- **Abort and reset:** drop `game_active` or assert `resetN`=0 during ISSUE → `spawn_valid` low next cycle, state IDLE, no spawn counted. For `game_active`, the lane pointer keeps its value. For `resetN`, the lane pointer is 0.

Source files
------------

// File: rtl/traffic_spawn_scheduler.sv
// traffic_spawn_scheduler
// Paces enemy-vehicle spawns for the road scene. Each frame tick counts a
// level-dependent gap down; at zero (with a free slot) it pulses `rise` to
// the random car/truck generator, samples `create_car` two cycles later and,
// on a positive decision, offers {slot, lane, type} to the slot bank over a
// valid/ack handshake.
//
// Ports
//   clk, resetN        : clock, synchronous active-low reset
//   startOfFrame       : one-cycle frame tick
//   game_active        : spawning enabled while high; low forces IDLE
//   level[2:0]         : difficulty, selects the gap at each reload
//   create_car         : generator decision, sampled in DECIDE
//   slot_busy[N_SLOTS] : occupied object slots
//   rise               : one-cycle request pulse to the generator
//   spawn_valid        : spawn offer pending
//   spawn_slot/lane    : latched target slot and lane
//   spawn_is_truck     : latched type (1 = truck)
//   spawn_ack          : slot logic accepts the offer
module traffic_spawn_scheduler #(
  parameter int N_SLOTS     = 4,
  parameter int N_LANES     = 4,
  parameter int BASE_GAP    = 60,
  parameter int GAP_STEP    = 6,
  parameter int MIN_GAP     = 12,
  parameter int TRUCK_EVERY = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       game_active,
  input  logic [2:0]                 level,
  input  logic                       create_car,
  input  logic [N_SLOTS-1:0]         slot_busy,
  output logic                       rise,
  output logic                       spawn_valid,
  output logic [$clog2(N_SLOTS)-1:0] spawn_slot,
  output logic [$clog2(N_LANES)-1:0] spawn_lane,
  output logic                       spawn_is_truck,
  input  logic                       spawn_ack
);

  localparam int SW = $clog2(N_SLOTS);
  localparam int LW = $clog2(N_LANES);
  localparam int CW = (TRUCK_EVERY > 1) ? $clog2(TRUCK_EVERY) : 1;

  typedef enum logic [2:0] {IDLE, GAP, REQ, WAIT_RND, DECIDE, ISSUE} state_t;

  state_t        state_q;
  logic [7:0]    gap_q;
  logic [LW-1:0] lane_q;
  logic [CW-1:0] cnt_q;

  // Gap for the current level, floored at MIN_GAP. An over-large level
  // product saturates to the floor rather than wrapping to a huge gap.
  logic [7:0] prod, diff, gap_val;
  always_comb begin
    prod    = 8'(level) * 8'(GAP_STEP);
    diff    = 8'(BASE_GAP) - prod;
    gap_val = 8'(MIN_GAP);
    if (prod < 8'(BASE_GAP) && diff > 8'(MIN_GAP))
      gap_val = diff;
  end

  // Lowest-index free slot; scanning downward lets the lowest one win.
  logic          any_free;
  logic [SW-1:0] free_idx;
  always_comb begin
    any_free = ~&slot_busy;
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (!slot_busy[i]) free_idx = SW'(i);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= IDLE;
      gap_q          <= '0;
      lane_q         <= '0;
      cnt_q          <= '0;
      rise           <= 1'b0;
      spawn_valid    <= 1'b0;
      spawn_slot     <= '0;
      spawn_lane     <= '0;
      spawn_is_truck <= 1'b0;
    end else if (!game_active) begin
      // Abort from any state; lane pointer and spawn counter are kept.
      state_q     <= IDLE;
      gap_q       <= '0;
      rise        <= 1'b0;
      spawn_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          gap_q   <= gap_val;
          state_q <= GAP;
        end
        GAP: begin
          if (gap_q == 8'd0) begin
            // Hold at zero while every slot is occupied.
            if (any_free) begin
              rise    <= 1'b1;
              state_q <= REQ;
            end
          end else if (startOfFrame) begin
            gap_q <= gap_q - 8'd1;
          end
        end
        REQ: begin
          rise    <= 1'b0;
          state_q <= WAIT_RND;
        end
        WAIT_RND: state_q <= DECIDE;
        DECIDE: begin
          // Slot is re-evaluated here; none free counts as a skip.
          if (create_car && any_free) begin
            spawn_slot     <= free_idx;
            spawn_lane     <= lane_q;
            spawn_is_truck <= (cnt_q == CW'(TRUCK_EVERY - 1));
            spawn_valid    <= 1'b1;
            state_q        <= ISSUE;
          end else begin
            gap_q   <= gap_val;
            state_q <= GAP;
          end
        end
        ISSUE: begin
          if (spawn_ack) begin
            spawn_valid <= 1'b0;
            lane_q      <= (lane_q == LW'(N_LANES - 1)) ? '0 : lane_q + LW'(1);
            cnt_q       <= (cnt_q == CW'(TRUCK_EVERY - 1)) ? '0 : cnt_q + CW'(1);
            gap_q       <= gap_val;
            state_q     <= GAP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_spawn_scheduler.sv
// Directed bench for traffic_spawn_scheduler with default parameters.
module tb_traffic_spawn_scheduler;

  logic       clk = 1'b0;
  logic       resetN, sof, game_active, create_car, spawn_ack;
  logic [2:0] level;
  logic [3:0] slot_busy;
  logic       rise, spawn_valid, spawn_is_truck;
  logic [1:0] spawn_slot, spawn_lane;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  traffic_spawn_scheduler dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (sof),
    .game_active   (game_active),
    .level         (level),
    .create_car    (create_car),
    .slot_busy     (slot_busy),
    .rise          (rise),
    .spawn_valid   (spawn_valid),
    .spawn_slot    (spawn_slot),
    .spawn_lane    (spawn_lane),
    .spawn_is_truck(spawn_is_truck),
    .spawn_ack     (spawn_ack)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs until rise; returns frame ticks issued (pulse=1) or cycles (pulse=0).
  task automatic wait_rise(input bit pulse, input int mid_lvl, output int cnt);
    int n, cyc;
    bit ph;
    n = 0; cyc = 0; ph = 1'b1;
    while (!rise && cyc < 400) begin
      sof = pulse & ph;
      ph  = ~ph;
      step();
      if (sof) n++;
      cyc++;
      sof = 1'b0;
      if (mid_lvl >= 0 && n == 5) level = 3'(mid_lvl);
    end
    cnt = pulse ? n : cyc;
  endtask

  task automatic do_spawn(input string tag, input bit pulse, input int exp_n,
                          input int e_slot, input int e_lane, input bit e_trk,
                          input int nlvl, input int mid_lvl, input int hold,
                          input bit do_ack);
    int cnt, cyc;
    logic [3:0] saved;
    logic [5:0] exp_off;
    wait_rise(pulse, mid_lvl, cnt);
    chk({tag, "_gap"}, cnt, exp_n);
    step();
    chk({tag, "_rise1"}, int'(rise), 0);
    cyc = 1;
    while (!spawn_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk({tag, "_vlat"}, cyc, 3);
    chk({tag, "_slot"}, int'(spawn_slot), e_slot);
    chk({tag, "_lane"}, int'(spawn_lane), e_lane);
    chk({tag, "_trk"},  int'(spawn_is_truck), int'(e_trk));
    saved   = slot_busy;
    exp_off = {1'b1, 2'(e_slot), 2'(e_lane), e_trk};
    for (int i = 0; i < hold; i++) begin
      slot_busy = 4'($urandom);
      step();
      chk($sformatf("%s_hold%0d", tag, i),
          int'({spawn_valid, spawn_slot, spawn_lane, spawn_is_truck}), int'(exp_off));
    end
    slot_busy = saved;
    if (do_ack) begin
      level     = 3'(nlvl);
      spawn_ack = 1'b1;
      step();
      spawn_ack = 1'b0;
      chk({tag, "_ackdrop"}, int'(spawn_valid), 0);
    end
  endtask

  initial begin
    int cnt;
    resetN = 1'b0; sof = 1'b0; game_active = 1'b0; create_car = 1'b1;
    spawn_ack = 1'b0; level = 3'd0; slot_busy = 4'b0000;
    step(); step();
    chk("rst_rise",  int'(rise), 0);
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_slot",  int'(spawn_slot), 0);
    chk("rst_lane",  int'(spawn_lane), 0);
    chk("rst_trk",   int'(spawn_is_truck), 0);

    resetN = 1'b1; game_active = 1'b1;
    step();                                  // IDLE -> GAP, gap 60 loaded
    do_spawn("s1", 1, 60, 0, 0, 0, 7, -1, 0, 1);
    do_spawn("s2", 1, 18, 0, 1, 0, 7, -1, 0, 1);
    do_spawn("s3", 1, 18, 0, 2, 0, 7, -1, 0, 1);
    do_spawn("s4", 1, 18, 0, 3, 1, 7, -1, 0, 1);
    do_spawn("s5", 1, 18, 0, 0, 0, 7, -1, 0, 1);
    do_spawn("s6", 1, 18, 0, 1, 0, 7, -1, 0, 1);
    do_spawn("s7", 1, 18, 0, 2, 0, 7, -1, 0, 1);
    // Level 6 applied mid-gap: this gap stays 18, the next one is 24.
    do_spawn("s8", 1, 18, 0, 3, 1, 6, 6, 0, 1);
    slot_busy = 4'b1011;
    do_spawn("s9", 1, 24, 2, 0, 0, 7, -1, 0, 1);

    // All slots busy: gap expires but no request is made.
    slot_busy = 4'b1111;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      sof = i[0] ? 1'b0 : 1'b1;
      step();
      sof = 1'b0;
      if (rise) cnt++;
    end
    chk("allbusy_norise", cnt, 0);
    slot_busy = 4'b0111;
    do_spawn("s10", 0, 1, 3, 1, 0, 7, -1, 0, 1);
    slot_busy = 4'b0000;

    // Skip: no offer, lane pointer unchanged, fresh gap.
    create_car = 1'b0;
    wait_rise(1, -1, cnt);
    chk("skip_gap", cnt, 18);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (spawn_valid) cnt++;
    end
    chk("skip_novalid", cnt, 0);
    create_car = 1'b1;
    do_spawn("s11", 1, 18, 0, 2, 0, 7, -1, 0, 1);
    do_spawn("s12", 1, 18, 0, 3, 1, 7, -1, 10, 1);
    do_spawn("s13", 1, 18, 0, 0, 0, 7, -1, 0, 1);

    // Abort by game_active during ISSUE; lane pointer survives.
    do_spawn("s14", 1, 18, 0, 1, 0, 7, -1, 0, 0);
    game_active = 1'b0;
    step();
    chk("abort_valid", int'(spawn_valid), 0);
    chk("abort_rise",  int'(rise), 0);
    game_active = 1'b1;
    step();
    do_spawn("s15", 1, 18, 0, 1, 0, 7, -1, 0, 1);

    // Reset during ISSUE; lane pointer returns to 0.
    do_spawn("s16", 1, 18, 0, 2, 0, 7, -1, 0, 0);
    resetN = 1'b0;
    step();
    chk("rstiss_valid", int'(spawn_valid), 0);
    chk("rstiss_lane",  int'(spawn_lane), 0);
    resetN = 1'b1;
    step();
    do_spawn("s17", 1, 18, 0, 0, 0, 7, -1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
